// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator.
// Optional LFSR gap fill is enabled by defining SEQ_GEN_LFSR_GAP_EN.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } seq_gen_state_t;

    localparam int unsigned SEQ_REP_W = 8;

    // x^7 + x^6 + 1: feedback from the two MSBs
    localparam int unsigned LFSR_W    = 7;
    localparam logic [6:0]  LFSR_SEED = 7'h01;
    localparam logic [6:0]  LFSR_TAPS = 7'h60;

endpackage

// File: rtl/seq_gen_lfsr.sv
// 7-bit Fibonacci LFSR supplying pseudo-random gap fill bits.
// Only instantiated when SEQ_GEN_LFSR_GAP_EN is defined.
module seq_gen_lfsr
    import seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic advance,
    output logic bit_o
);

    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (advance) begin
            lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign bit_o = lfsr_q[LFSR_W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: PATTERN MSB first, repeat_cnt+1 frames separated by gap bits.
// Define SEQ_GEN_LFSR_GAP_EN to fill gaps from an LFSR instead of constant 0.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int unsigned          PATTERN_W = 2,
    parameter logic [PATTERN_W-1:0] PATTERN   = 2'b11,
    parameter int unsigned          GAP_LEN   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SEQ_REP_W-1:0] repeat_cnt,
    output logic                 out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
    localparam int unsigned GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PATTERN_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_LEN > 0) ? GAP_W'(GAP_LEN - 1) : '0;

    seq_gen_state_t       state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [SEQ_REP_W-1:0] frames_q, frames_d;
    logic                 out_q, out_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 pat_bit;
    logic                 gap_bit;

    assign pat_bit = PATTERN[IDX_LAST - idx_q];

`ifdef SEQ_GEN_LFSR_GAP_EN
    seq_gen_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (state_q == GAP),
        .bit_o   (gap_bit)
    );
`else
    assign gap_bit = 1'b0;
`endif

    // The FSM runs one cycle ahead of the output register, so the last
    // output bit is on the line while state_q is already IDLE; valid_q
    // keeps start blocked until the done cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        frames_d = frames_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort && !valid_q) begin
                    state_d  = SEND;
                    idx_d    = '0;
                    gap_d    = '0;
                    frames_d = repeat_cnt;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    gap_d    = '0;
                    frames_d = '0;
                end else if (idx_q == IDX_LAST) begin
                    idx_d = '0;
                    if (frames_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        frames_d = frames_q - SEQ_REP_W'(1);
                        gap_d    = '0;
                        state_d  = (GAP_LEN == 0) ? SEND : GAP;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            GAP: begin
                if (abort) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    gap_d    = '0;
                    frames_d = '0;
                end else if (gap_q == GAP_LAST) begin
                    state_d = SEND;
                    idx_d   = '0;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d   = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (!abort) begin
            if (state_q == SEND) begin
                out_d = pat_bit;
            end else if (state_q == GAP) begin
                out_d = gap_bit;
            end
            valid_d = (state_q != IDLE);
            // Valid still high with the FSM idle marks the final bit cycle.
            done_d  = valid_q && (state_q == IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            gap_q    <= '0;
            frames_q <= '0;
            out_q    <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            frames_q <= frames_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign busy      = valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: a default 2'b11/gap-1 instance and a 4'b1011/gap-0 instance.
module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, abort;
    logic [7:0] repeat_cnt;
    logic       out, out_valid, busy, done;
    logic       start4, abort4;
    logic [7:0] rc4;
    logic       out4, valid4, busy4, done4;

    int         n_tests = 0;
    int         n_fail  = 0;
    bit         exp_q[$];
    bit         got_q[$];
    bit         exp_snap[$];
    logic [6:0] m_lfsr;

    always #5 clk = ~clk;

    seq_pattern_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .repeat_cnt (repeat_cnt),
        .out        (out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    seq_pattern_gen #(
        .PATTERN_W (4),
        .PATTERN   (4'b1011),
        .GAP_LEN   (0)
    ) dut4 (
        .clk        (clk),
        .reset      (reset),
        .start      (start4),
        .abort      (abort4),
        .repeat_cnt (rc4),
        .out        (out4),
        .out_valid  (valid4),
        .busy       (busy4),
        .done       (done4)
    );

    task automatic model_gap(output bit b);
`ifdef SEQ_GEN_LFSR_GAP_EN
        b      = m_lfsr[6];
        m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
`else
        b = 1'b0;
`endif
    endtask

    task automatic push_frames(input int pw, input logic [3:0] pat, input int gap, input int frames);
        bit g;
        for (int f = 0; f < frames; f++) begin
            for (int b = pw - 1; b >= 0; b--) exp_q.push_back(pat[b]);
            if (f < frames - 1) begin
                for (int k = 0; k < gap; k++) begin
                    model_gap(g);
                    exp_q.push_back(g);
                end
            end
        end
        exp_snap = exp_q;
    endtask

    task automatic pulse_start(input bit use4, input logic [7:0] rc);
        if (use4) begin start4 = 1'b1; rc4 = rc; end
        else begin start = 1'b1; repeat_cnt = rc; end
        @(negedge clk);
        start  = 1'b0;
        start4 = 1'b0;
        n_tests++;
        if ((use4 ? valid4 : out_valid) !== 1'b0) begin
            n_fail++;
            $display("FAIL latency: out_valid=%b in cycle after accept, want 0",
                     use4 ? valid4 : out_valid);
        end
    endtask

    // Scoreboard consumer: pops one expected bit per valid cycle until done.
    task automatic drain(input bit use4, input string name, input int budget,
                         output int nvalid, output int nbusy, output bit saw_done);
        bit o, v, b, d, e, started;
        nvalid = 0; nbusy = 0; saw_done = 1'b0; started = 1'b0;
        got_q.delete();
        for (int i = 0; i < budget && !saw_done; i++) begin
            @(negedge clk);
            o = use4 ? out4 : out;
            v = use4 ? valid4 : out_valid;
            b = use4 ? busy4 : busy;
            d = use4 ? done4 : done;
            if (b) nbusy++;
            if (d) begin
                saw_done = 1'b1;
                n_tests++;
                if ({v, b} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL %s done_cycle: valid,busy=%b want 00", name, {v, b});
                end
            end else if (started) begin
                n_tests++;
                if (v !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s valid_hole: out_valid=%b want 1", name, v);
                end
            end
            if (v) begin
                started = 1'b1;
                nvalid++;
                got_q.push_back(o);
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra_bit: got %b, want no valid bit", name, o);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        n_fail++;
                        $display("FAIL %s bit%0d: got %b want %b", name, nvalid - 1, o, e);
                    end
                end
            end
        end
        n_tests++;
        if (!saw_done) begin
            n_fail++;
            $display("FAIL %s timeout: done=0 after %0d cycles, want 1", name, budget);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s missing_bits: %0d left, want 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_lfsr = 7'h01;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        start = 0; abort = 0; repeat_cnt = 0; start4 = 0; abort4 = 0; rc4 = 0;
        reset = 1'b0;
        m_lfsr = 7'h01;
        @(negedge clk);
        n_tests++;
        if ({out, out_valid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_active: out,valid,busy,done=%b want 0000",
                     {out, out_valid, busy, done});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({out, out_valid, busy, done, out4, valid4, busy4, done4} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_release: outputs=%b want 00000000",
                     {out, out_valid, busy, done, out4, valid4, busy4, done4});
        end
    endtask

    task automatic test_single();
        int nv, nb;
        bit sd;
        push_frames(2, 4'b0011, 1, 1);
        pulse_start(1'b0, 8'd0);
        drain(1'b0, "single", 10, nv, nb, sd);
        n_tests++;
        if (nv != 2 || nb != 2) begin
            n_fail++;
            $display("FAIL single_len: valid=%0d busy=%0d want 2 2", nv, nb);
        end
    endtask

    task automatic test_back_to_back();
        int nv, nb;
        bit sd;
        // Start issued in the done cycle of the previous burst.
        push_frames(2, 4'b0011, 1, 1);
        pulse_start(1'b0, 8'd0);
        drain(1'b0, "b2b_a", 10, nv, nb, sd);
        push_frames(2, 4'b0011, 1, 2);
        pulse_start(1'b0, 8'd1);
        drain(1'b0, "b2b_b", 20, nv, nb, sd);
        n_tests++;
        if (nv != 5) begin
            n_fail++;
            $display("FAIL b2b_len: valid=%0d want 5", nv);
        end
    endtask

    task automatic test_repeat();
        int nv, nb, m_got, m_exp;
        bit sd;
        push_frames(2, 4'b0011, 1, 3);
        pulse_start(1'b0, 8'd2);
        drain(1'b0, "repeat", 30, nv, nb, sd);
        n_tests++;
        if (nv != 8 || nb != 8) begin
            n_fail++;
            $display("FAIL repeat_len: valid=%0d busy=%0d want 8 8", nv, nb);
        end
        m_got = 0; m_exp = 0;
        for (int i = 1; i < got_q.size(); i++) if (got_q[i-1] && got_q[i]) m_got++;
        for (int i = 1; i < exp_snap.size(); i++) if (exp_snap[i-1] && exp_snap[i]) m_exp++;
        n_tests++;
        if (m_got != m_exp) begin
            n_fail++;
            $display("FAIL repeat_matches11: got %0d want %0d", m_got, m_exp);
        end
    endtask

    task automatic test_pattern4();
        int nv, nb;
        bit sd;
        push_frames(4, 4'b1011, 0, 2);
        pulse_start(1'b1, 8'd1);
        drain(1'b1, "pat4", 20, nv, nb, sd);
        n_tests++;
        if (nv != 8) begin
            n_fail++;
            $display("FAIL pat4_len: valid=%0d want 8", nv);
        end
    endtask

    task automatic test_abort();
        bit g, e, bad;
        int nv, nb;
        bit sd;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        model_gap(g);
        exp_q.push_back(g);
        pulse_start(1'b0, 8'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_tests++;
            if (out_valid !== 1'b1 || out !== e) begin
                n_fail++;
                $display("FAIL abort_pre%0d: valid,out=%b%b want 1%b", k, out_valid, out, e);
            end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++;
        if ({out, out_valid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_next: out,valid,busy,done=%b want 0000",
                     {out, out_valid, busy, done});
        end
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || out_valid || busy) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL abort_quiet: activity after abort=1 want 0");
        end
        push_frames(2, 4'b0011, 1, 3);
        pulse_start(1'b0, 8'd2);
        drain(1'b0, "abort_fresh", 30, nv, nb, sd);
        n_tests++;
        if (nv != 8) begin
            n_fail++;
            $display("FAIL abort_fresh_len: valid=%0d want 8", nv);
        end
    endtask

    task automatic test_ignored_start();
        bit e, bad;
        int nv, nd;
        start = 1'b1; abort = 1'b1; repeat_cnt = 8'd3;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid || busy || done) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL start_abort_idle: burst started=1 want 0");
        end
        push_frames(2, 4'b0011, 1, 2);
        pulse_start(1'b0, 8'd1);
        nv = 0; nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) nd++;
            if (out_valid) begin
                nv++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL ignored_extra: got %b want no bit", out);
                end else begin
                    e = exp_q.pop_front();
                    if (out !== e) begin
                        n_fail++;
                        $display("FAIL ignored_bit%0d: got %b want %b", nv - 1, out, e);
                    end
                end
                // Start requests mid-burst and on the final bit cycle.
                if (nv == 2 || nv == 5) begin
                    start = 1'b1;
                    repeat_cnt = 8'd7;
                end
            end
        end
        n_tests++;
        if (nv != 5 || nd != 1) begin
            n_fail++;
            $display("FAIL ignored_counts: valid=%0d done=%0d want 5 1", nv, nd);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_gap();
        int nv, nb;
        bit sd;
        push_frames(2, 4'b0011, 1, 3);
        pulse_start(1'b0, 8'd2);
        repeat (3) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstgap_in_gap: out_valid=%b want 1", out_valid);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({out, out_valid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstgap_async: out,valid,busy,done=%b want 0000",
                     {out, out_valid, busy, done});
        end
        exp_q.delete();
        m_lfsr = 7'h01;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({out, out_valid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstgap_release: outputs=%b want 0000", {out, out_valid, busy, done});
        end
        push_frames(2, 4'b0011, 1, 2);
        pulse_start(1'b0, 8'd1);
        drain(1'b0, "rstgap_fresh", 20, nv, nb, sd);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_repeat();
        test_pattern4();
        test_abort();
        do_reset();
        test_ignored_start();
        test_reset_gap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
